// File: rtl/acc_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module : acc_cpu_sequencer
// Desc   : Multi-cycle fetch/decode/execute controller for the accumulator ALU.
//          Define ACC_CPU_SEQUENCER_STEP_EN to add the single-step PAUSE state.
// Rev    : 1.0
// ============================================================================
module acc_cpu_sequencer #(
   parameter int DATA_SIZE   = 8,
   parameter int OPCODE_SIZE = 4,
   parameter int INSTR_SIZE  = 12,
   parameter int ADDR_SIZE   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef ACC_CPU_SEQUENCER_STEP_EN
   input  logic                  step,
`endif
   output logic [ADDR_SIZE-1:0]  mem_addr,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [INSTR_SIZE-1:0] mem_wdata,
   input  logic [INSTR_SIZE-1:0] mem_rdata,
   output logic [INSTR_SIZE-1:0] instr_reg,
   output logic [DATA_SIZE-1:0]  accumulator,
   output logic [DATA_SIZE-1:0]  from_mem_data,
   input  logic [DATA_SIZE-1:0]  alu_out,
   input  logic                  we_alu,
   output logic [ADDR_SIZE-1:0]  pc,
   output logic                  halted
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_LOAD_IR = 3'd1,
      S_DECODE  = 3'd2,
      S_OPERAND = 3'd3,
      S_EXEC    = 3'd4,
      S_HALT    = 3'd5
`ifdef ACC_CPU_SEQUENCER_STEP_EN
      , S_PAUSE = 3'd6
`endif
   } state_t;

   localparam logic [OPCODE_SIZE-1:0] OP_MEM_FIRST = OPCODE_SIZE'(1);
   localparam logic [OPCODE_SIZE-1:0] OP_MEM_LAST  = OPCODE_SIZE'(6);
   localparam logic [OPCODE_SIZE-1:0] OP_REG_FIRST = OPCODE_SIZE'(7);
   localparam logic [OPCODE_SIZE-1:0] OP_REG_LAST  = OPCODE_SIZE'(11);
   localparam logic [OPCODE_SIZE-1:0] OP_JMP       = OPCODE_SIZE'(13);
   localparam logic [OPCODE_SIZE-1:0] OP_JZ        = OPCODE_SIZE'(14);
   localparam logic [OPCODE_SIZE-1:0] OP_HALT      = OPCODE_SIZE'(15);

   function automatic logic is_mem_op(input logic [OPCODE_SIZE-1:0] op);
      return (op >= OP_MEM_FIRST) && (op <= OP_MEM_LAST);
   endfunction

   function automatic logic is_reg_op(input logic [OPCODE_SIZE-1:0] op);
      return (op >= OP_REG_FIRST) && (op <= OP_REG_LAST);
   endfunction

   state_t                  state_q;
   logic [ADDR_SIZE-1:0]    pc_q;
   logic [ADDR_SIZE-1:0]    pc_d;
   logic [INSTR_SIZE-1:0]   instr_reg_q;
   logic [DATA_SIZE-1:0]    accumulator_q;
   logic [DATA_SIZE-1:0]    from_mem_data_q;
   logic [ADDR_SIZE-1:0]    mem_addr_q;
   logic [INSTR_SIZE-1:0]   mem_wdata_q;
   logic                    mem_rd_q;
   logic                    mem_wr_q;
   logic                    halted_q;

   logic [OPCODE_SIZE-1:0]  ir_op;
   logic [OPCODE_SIZE-1:0]  rd_op;
   logic [ADDR_SIZE-1:0]    ir_f;
   logic                    enter_exec;

   assign ir_op      = instr_reg_q[INSTR_SIZE-1 -: OPCODE_SIZE];
   assign rd_op      = mem_rdata[INSTR_SIZE-1 -: OPCODE_SIZE];
   assign ir_f       = instr_reg_q[ADDR_SIZE-1:0];
   assign enter_exec = ((state_q == S_DECODE) && !is_mem_op(ir_op)) || (state_q == S_OPERAND);

   always_comb begin
      pc_d = pc_q;
      if ((ir_op == OP_JMP) || ((ir_op == OP_JZ) && (accumulator_q == '0))) begin
         pc_d = ir_f;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_FETCH;
         pc_q            <= '0;
         instr_reg_q     <= '0;
         accumulator_q   <= '0;
         from_mem_data_q <= '0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         mem_rd_q        <= 1'b0;
         mem_wr_q        <= 1'b0;
         halted_q        <= 1'b0;
      end else begin
         case (state_q)
            // Leaving reset, FETCH has not yet issued its read; issue it first.
            S_FETCH: begin
               if (!mem_rd_q) begin
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= pc_q;
               end else begin
                  mem_rd_q <= 1'b0;
                  state_q  <= S_LOAD_IR;
               end
            end
            S_LOAD_IR: begin
               instr_reg_q <= mem_rdata;
               pc_q        <= pc_q + ADDR_SIZE'(1);
               state_q     <= S_DECODE;
               if (is_mem_op(rd_op)) begin
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= mem_rdata[ADDR_SIZE-1:0];
               end
            end
            S_DECODE: begin
               mem_rd_q <= 1'b0;
               state_q  <= is_mem_op(ir_op) ? S_OPERAND : S_EXEC;
            end
            S_OPERAND: begin
               from_mem_data_q <= mem_rdata[DATA_SIZE-1:0];
               state_q         <= S_EXEC;
            end
            S_EXEC: begin
               mem_wr_q <= 1'b0;
               pc_q     <= pc_d;
               if (!mem_wr_q && (is_mem_op(ir_op) || is_reg_op(ir_op))) begin
                  accumulator_q <= alu_out;
               end
               if (ir_op == OP_HALT) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else begin
`ifdef ACC_CPU_SEQUENCER_STEP_EN
                  state_q <= S_PAUSE;
`else
                  state_q    <= S_FETCH;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= pc_d;
`endif
               end
            end
            S_HALT: begin
               halted_q <= 1'b1;
            end
`ifdef ACC_CPU_SEQUENCER_STEP_EN
            S_PAUSE: begin
               if (step) begin
                  state_q    <= S_FETCH;
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= pc_q;
               end
            end
`endif
            default: begin
               state_q <= S_FETCH;
            end
         endcase

         // The write strobe is owned by the ALU's store request, not the opcode.
         if (enter_exec) begin
            mem_wr_q <= we_alu;
            if (we_alu) begin
               mem_addr_q  <= ir_f;
               mem_wdata_q <= INSTR_SIZE'(alu_out);
            end
         end
      end
   end

   assign mem_addr      = mem_addr_q;
   assign mem_rd        = mem_rd_q;
   assign mem_wr        = mem_wr_q;
   assign mem_wdata     = mem_wdata_q;
   assign instr_reg     = instr_reg_q;
   assign accumulator   = accumulator_q;
   assign from_mem_data = from_mem_data_q;
   assign pc            = pc_q;
   assign halted        = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu_sequencer.sv
`default_nettype none
// Bench for acc_cpu_sequencer: directed programs plus random programs compared
// against an instruction-level reference model; a small ALU and memory surround the DUT.
module tb_acc_cpu_sequencer;

`ifdef ACC_CPU_SEQUENCER_STEP_EN
   localparam int EXTRA = 1;
   logic step = 1'b1;
`else
   localparam int EXTRA = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;
   logic [11:0] instr_reg;
   logic [7:0]  accumulator;
   logic [7:0]  from_mem_data;
   logic [7:0]  alu_out;
   logic        we_alu;
   logic [7:0]  pc;
   logic        halted;

   logic [11:0] mem [256];
   logic [11:0] img [256];
   logic        load_req = 1'b0;

   int          checks = 0;
   int          failures = 0;
   int          wr_cnt = 0;
   int          overlap_cnt = 0;
   logic [7:0]  wr_addr;
   logic [11:0] wr_data;

   logic [11:0] m_mem [256];
   logic [7:0]  m_acc;
   logic [7:0]  m_pc;
   logic [7:0]  m_opnd;
   int          m_stores;

   always #5 clk = ~clk;

   acc_cpu_sequencer dut (
      .clk          (clk),
      .rst          (rst),
`ifdef ACC_CPU_SEQUENCER_STEP_EN
      .step         (step),
`endif
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .instr_reg    (instr_reg),
      .accumulator  (accumulator),
      .from_mem_data(from_mem_data),
      .alu_out      (alu_out),
      .we_alu       (we_alu),
      .pc           (pc),
      .halted       (halted)
   );

   // Accumulator ALU: {store request, result}.
   function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] d, input logic [7:0] f);
      case (op)
         4'h1: return {1'b0, d};
         4'h2: return {1'b0, a + d};
         4'h3: return {1'b0, a - d};
         4'h4: return {1'b0, a & d};
         4'h5: return {1'b0, a | d};
         4'h6: return {1'b0, a ^ d};
         4'h7: return {1'b0, ~a};
         4'h8: return {1'b0, a >> 1};
         4'h9: return {1'b0, a << 1};
         4'hA: return {1'b0, f};
         4'hB: return {1'b0, a + f};
         4'hC: return {1'b1, a};
         default: return {1'b0, a};
      endcase
   endfunction

   assign {we_alu, alu_out} = alu_fn(instr_reg[11:8], accumulator, from_mem_data, instr_reg[7:0]);

   always @(posedge clk) begin
      if (load_req) begin
         mem <= img;
      end else begin
         if (mem_wr) mem[mem_addr] <= mem_wdata;
         if (mem_rd) mem_rdata <= mem[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (mem_wr) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= mem_addr;
         wr_data <= mem_wdata;
      end
      if (mem_rd && mem_wr) overlap_cnt <= overlap_cnt + 1;
   end

   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 12'h000;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1ns into the first FETCH cycle (cycle 0).
   task automatic do_reset();
      rst = 1'b1;
      load_req = 1'b1;
      @(posedge clk);
      #1 load_req = 1'b0;
      for (int i = 0; i < 256; i++) m_mem[i] = img[i];
      m_acc = 8'h00;
      m_pc = 8'h00;
      m_opnd = 8'h00;
      m_stores = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Executes one instruction at ISA level; returns its cycle count.
   task automatic model_step(output int cyc);
      logic [11:0] ins;
      logic [3:0]  op;
      logic [7:0]  f;
      logic [7:0]  acc0;
      logic [8:0]  r;
      ins  = m_mem[m_pc];
      m_pc = m_pc + 8'd1;
      op   = ins[11:8];
      f    = ins[7:0];
      acc0 = m_acc;
      cyc  = 4;
      if (op >= 4'h1 && op <= 4'h6) begin
         m_opnd = m_mem[f][7:0];
         cyc = 5;
      end
      r = alu_fn(op, acc0, m_opnd, f);
      if (r[8]) begin
         m_mem[f] = {4'h0, r[7:0]};
         m_stores++;
      end else if (op >= 4'h1 && op <= 4'hB) begin
         m_acc = r[7:0];
      end
      if (op == 4'hD || (op == 4'hE && acc0 == 8'h00)) m_pc = f;
   endtask

   task automatic test_reset();
      clear_img();
      rst = 1'b1;
      load_req = 1'b1;
      @(posedge clk);
      #1 load_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({pc, instr_reg, accumulator, from_mem_data, mem_addr, mem_wdata, mem_rd, mem_wr, halted} !== 59'd0) begin
            failures++;
            $display("FAIL reset_outputs cycle %0d: got pc=%h ir=%h acc=%h rd=%b wr=%b halted=%b, expected all 0",
                     c, pc, instr_reg, accumulator, mem_rd, mem_wr, halted);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL first_fetch: got rd=%b wr=%b addr=%h, expected rd=1 wr=0 addr=00", mem_rd, mem_wr, mem_addr);
      end
   endtask

   task automatic test_load_add();
      clear_img();
      img[0] = 12'h110; img[1] = 12'h211; img[16] = 12'h005; img[17] = 12'h003;
      do_reset();
      run(5 + EXTRA);
      checks++;
      if (accumulator !== 8'h05) begin
         failures++;
         $display("FAIL load_acc: got %h expected 05", accumulator);
      end
      run(5 + EXTRA);
      checks++;
      if ({accumulator, pc} !== {8'h08, 8'h02}) begin
         failures++;
         $display("FAIL add_acc_pc: got acc=%h pc=%h expected acc=08 pc=02", accumulator, pc);
      end
   endtask

   task automatic test_reg_ops();
      logic [7:0] exp_acc [3];
      exp_acc[0] = 8'h7F; exp_acc[1] = 8'h80; exp_acc[2] = 8'h00;
      clear_img();
      img[0] = 12'hA7F; img[1] = 12'hB01; img[2] = 12'h900;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run(4 + EXTRA);
         checks++;
         if ({accumulator, mem_rd, mem_addr} !== {exp_acc[i], 1'b1, 8'(i + 1)}) begin
            failures++;
            $display("FAIL reg_op %0d: got acc=%h rd=%b addr=%h expected acc=%h rd=1 addr=%h",
                     i, accumulator, mem_rd, mem_addr, exp_acc[i], 8'(i + 1));
         end
      end
   endtask

   task automatic test_store();
      int base;
      clear_img();
      img[0] = 12'hA5A; img[1] = 12'hC20; img[32] = 12'h123;
      do_reset();
      base = wr_cnt;
      run(4 + EXTRA);
      run(4 + EXTRA);
      checks++;
      if ({wr_cnt - base, wr_addr, wr_data, accumulator, mem[32]} !== {32'd1, 8'h20, 12'h05A, 8'h5A, 12'h05A}) begin
         failures++;
         $display("FAIL store: got writes=%0d addr=%h data=%h acc=%h mem=%h expected 1 20 05A 5A 05A",
                  wr_cnt - base, wr_addr, wr_data, accumulator, mem[32]);
      end
   endtask

   task automatic test_rst_during_store();
      int base;
      clear_img();
      img[0] = 12'hA5A; img[1] = 12'hC20; img[32] = 12'h123;
      do_reset();
      base = wr_cnt;
      run(4 + EXTRA);
      run(3);
      checks++;
      if (mem_wr !== 1'b1) begin
         failures++;
         $display("FAIL store_exec_strobe: got mem_wr=%b expected 1", mem_wr);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (mem_wr !== 1'b0) begin
         failures++;
         $display("FAIL rst_drops_wr: got mem_wr=%b expected 0", mem_wr);
      end
      run(2);
      checks++;
      if ({wr_cnt - base, mem[32]} !== {32'd0, 12'h123}) begin
         failures++;
         $display("FAIL rst_no_write: got writes=%0d mem=%h expected 0 123", wr_cnt - base, mem[32]);
      end
   endtask

   task automatic test_branch();
      for (int t = 0; t < 2; t++) begin
         clear_img();
         img[0] = (t == 0) ? 12'hA00 : 12'hA01;
         img[1] = 12'hE08;
         do_reset();
         run(4 + EXTRA);
         run(4 + EXTRA);
         checks++;
         if ({pc, mem_addr, mem_rd} !== {(t == 0) ? 8'h08 : 8'h02, (t == 0) ? 8'h08 : 8'h02, 1'b1}) begin
            failures++;
            $display("FAIL jz_%0d: got pc=%h addr=%h rd=%b expected pc=%h", t, pc, mem_addr, mem_rd,
                     (t == 0) ? 8'h08 : 8'h02);
         end
      end
   endtask

   task automatic test_halt();
      int bad;
      clear_img();
      img[0] = 12'hF00;
      do_reset();
      run(4);
      checks++;
      if (halted !== 1'b1) begin
         failures++;
         $display("FAIL halt_enter: got halted=%b expected 1", halted);
      end
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (halted !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || pc !== 8'h01) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL halt_hold: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_pc_wrap();
      clear_img();
      img[0] = 12'hDFF; img[255] = 12'h000;
      do_reset();
      run(4 + EXTRA);
      checks++;
      if (pc !== 8'hFF) begin
         failures++;
         $display("FAIL jmp_ff: got pc=%h expected FF", pc);
      end
      run(4 + EXTRA);
      checks++;
      if ({pc, mem_addr} !== {8'h00, 8'h00}) begin
         failures++;
         $display("FAIL pc_wrap: got pc=%h addr=%h expected 00 00", pc, mem_addr);
      end
   endtask

   task automatic test_random();
      int cyc;
      int base;
      int bad;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 256; i++) img[i] = {4'($urandom_range(0, 14)), 8'($urandom_range(0, 255))};
         do_reset();
         base = wr_cnt;
         for (int k = 0; k < 40; k++) begin
            model_step(cyc);
            run(cyc + EXTRA);
            checks++;
            if ({accumulator, pc, mem_addr, mem_rd, mem_wr, halted} !== {m_acc, m_pc, m_pc, 1'b1, 1'b0, 1'b0}) begin
               failures++;
               $display("FAIL random r%0d i%0d: got acc=%h pc=%h addr=%h rd=%b expected acc=%h pc=%h",
                        r, k, accumulator, pc, mem_addr, mem_rd, m_acc, m_pc);
            end
         end
         bad = 0;
         for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) bad++;
         checks++;
         if (bad != 0 || (wr_cnt - base) != m_stores) begin
            failures++;
            $display("FAIL random_mem r%0d: got %0d differing words, %0d writes; expected 0 and %0d writes",
                     r, bad, wr_cnt - base, m_stores);
         end
      end
   endtask

`ifdef ACC_CPU_SEQUENCER_STEP_EN
   task automatic test_step();
      int bad;
      step = 1'b0;
      clear_img();
      img[0] = 12'h110; img[1] = 12'h211; img[16] = 12'h005; img[17] = 12'h003;
      do_reset();
      run(5);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || accumulator !== 8'h05 || pc !== 8'h01) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL pause_park: got %0d bad cycles expected 0", bad);
      end
      for (int p = 0; p < 2; p++) begin
         @(negedge clk) step = 1'b1;
         @(negedge clk) step = 1'b0;
         run(10);
         checks++;
         if ({accumulator, pc} !== {8'h08, 8'(p + 2)}) begin
            failures++;
            $display("FAIL step_pulse %0d: got acc=%h pc=%h expected acc=08 pc=%h", p, accumulator, pc, 8'(p + 2));
         end
      end
      step = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_load_add();
      test_reg_ops();
      test_store();
      test_rst_during_store();
      test_branch();
      test_halt();
      test_pc_wrap();
      test_random();
`ifdef ACC_CPU_SEQUENCER_STEP_EN
      test_step();
`endif
      checks++;
      if (overlap_cnt != 0) begin
         failures++;
         $display("FAIL rd_wr_overlap: got %0d cycles expected 0", overlap_cnt);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
